// File: rtl/alu_core_param.sv
// Frame-fed parametrised ALU core: collects B, A and a command frame, validates
// frame types, opcode and CRC4, then streams the result bytes and a control word.
module alu_core_param #(
    parameter int DATA_BYTES = 4,
    parameter int EXT_OPS    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [9:0]  in_frame,
    output logic        in_ready,
    output logic        out_valid,
    output logic [10:0] out_word,
    input  logic        out_ready
);

    localparam int W   = 8 * DATA_BYTES;
    localparam int SHW = $clog2(W);

    localparam logic [4:0] CNT_A    = 5'(DATA_BYTES);
    localparam logic [4:0] CNT_CMD  = 5'(2 * DATA_BYTES);
    localparam logic [4:0] CNT_LAST = 5'(DATA_BYTES - 1);

    localparam logic [2:0] S_RECV      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_CALC      = 3'd2;
    localparam logic [2:0] S_SEND_DATA = 3'd3;
    localparam logic [2:0] S_SEND_CTL  = 3'd4;
    localparam logic [2:0] S_ERR_SEND  = 3'd5;

    localparam logic [7:0] CTL_ERR_DATA = 8'b11001001;
    localparam logic [7:0] CTL_ERR_OP   = 8'b10010011;
    localparam logic [7:0] CTL_ERR_CRC  = 8'b10100101;

    logic [2:0]   state_reg;
    logic [4:0]   cnt_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [3:0]   crc_reg;
    logic [6:0]   cmd_reg;
    logic [W-1:0] c_reg;
    logic [7:0]   ctl_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic [10:0]  out_word_reg;

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_word  = out_word_reg;

    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
        return {c[2:0], 1'b0} ^ ((c[3] ^ d) ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [2:0] crc3_calc(input logic [W+4:0] msg);
        logic [2:0] c;
        c = 3'h0;
        for (int i = W + 4; i >= 0; i--) begin
            c = {c[1:0], 1'b0} ^ ((c[2] ^ msg[i]) ? 3'h3 : 3'h0);
        end
        return c;
    endfunction

    logic         accept;
    logic         frame_err;
    logic [3:0]   crc_byte;
    logic [3:0]   crc_full;
    logic [3:0]   crc_tail;
    logic [2:0]   op;
    logic         op_illegal;
    logic         crc_bad;
    logic [W+7:0] a_shift;
    logic [W+7:0] b_shift;
    logic [W+7:0] c_shift;

    assign accept    = in_valid && in_ready_reg;
    assign frame_err = in_frame[9]
                     || (in_frame[8] && (cnt_reg != CNT_CMD))
                     || (!in_frame[8] && (cnt_reg == CNT_CMD));
    assign op        = cmd_reg[6:4];
    assign crc_tail  = {1'b1, op};
    assign a_shift   = {a_reg, in_frame[7:0]};
    assign b_shift   = {b_reg, in_frame[7:0]};
    assign c_shift   = {c_reg, 8'h00};

    // Extended opcodes are only legal when EXT_OPS is set; 11x is never legal.
    assign op_illegal = (op[2:1] == 2'b11) || ((EXT_OPS == 0) && (op[2:1] == 2'b01));
    assign crc_bad    = (cmd_reg[3:0] != crc_full);

    always_comb begin
        crc_byte = crc_reg;
        for (int i = 7; i >= 0; i--) begin
            crc_byte = crc4_step(crc_byte, in_frame[i]);
        end
        crc_full = crc_reg;
        for (int i = 3; i >= 0; i--) begin
            crc_full = crc4_step(crc_full, crc_tail[i]);
        end
    end

    logic [W:0]     wide;
    logic [W-1:0]   c_val;
    logic [SHW-1:0] sh;
    logic           carry;
    logic           ovf;
    logic           zero;
    logic           neg;
    logic [2:0]     crc3;
    logic [7:0]     ctl_val;

    // Bit W of the widened result is the carry, borrow or last shifted-out bit.
    always_comb begin
        wide  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        sh    = b_reg[SHW-1:0];
        case (op)
            3'b000: wide = {1'b0, a_reg & b_reg};
            3'b001: wide = {1'b0, a_reg | b_reg};
            3'b010: wide = {1'b0, a_reg ^ b_reg};
            3'b011: begin
                wide  = {1'b0, a_reg} << sh;
                carry = wide[W];
            end
            3'b100: begin
                wide  = {1'b0, a_reg} + {1'b0, b_reg};
                carry = wide[W];
                ovf   = (a_reg[W-1] == b_reg[W-1]) && (wide[W-1] != a_reg[W-1]);
            end
            3'b101: begin
                wide  = {1'b0, a_reg} - {1'b0, b_reg};
                carry = wide[W];
                ovf   = (a_reg[W-1] != b_reg[W-1]) && (wide[W-1] != a_reg[W-1]);
            end
            default: wide = '0;
        endcase
        c_val   = wide[W-1:0];
        zero    = (c_val == '0);
        neg     = c_val[W-1];
        crc3    = crc3_calc({c_val, 1'b0, carry, ovf, zero, neg});
        ctl_val = {1'b0, carry, ovf, zero, neg, crc3};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_RECV;
            cnt_reg       <= 5'd0;
            a_reg         <= '1;
            b_reg         <= '1;
            crc_reg       <= 4'h0;
            cmd_reg       <= 7'h0;
            c_reg         <= '0;
            ctl_reg       <= 8'h00;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_word_reg  <= 11'h7FF;
        end else begin
            case (state_reg)
                S_RECV: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        if (frame_err) begin
                            ctl_reg      <= CTL_ERR_DATA;
                            cnt_reg      <= 5'd0;
                            in_ready_reg <= 1'b0;
                            state_reg    <= S_ERR_SEND;
                        end else if (cnt_reg == CNT_CMD) begin
                            cmd_reg      <= in_frame[6:0];
                            in_ready_reg <= 1'b0;
                            state_reg    <= S_CHECK;
                        end else begin
                            crc_reg <= crc_byte;
                            if (cnt_reg < CNT_A) begin
                                b_reg <= b_shift[W-1:0];
                            end else begin
                                a_reg <= a_shift[W-1:0];
                            end
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (op_illegal) begin
                        ctl_reg   <= CTL_ERR_OP;
                        state_reg <= S_ERR_SEND;
                    end else if (crc_bad) begin
                        ctl_reg   <= CTL_ERR_CRC;
                        state_reg <= S_ERR_SEND;
                    end else begin
                        state_reg <= S_CALC;
                    end
                end
                S_CALC: begin
                    c_reg         <= c_val;
                    ctl_reg       <= ctl_val;
                    cnt_reg       <= 5'd0;
                    out_valid_reg <= 1'b1;
                    out_word_reg  <= {2'b00, c_val[W-1 -: 8], 1'b1};
                    state_reg     <= S_SEND_DATA;
                end
                S_SEND_DATA: begin
                    // cnt_reg is reused as the index of the byte currently on the bus.
                    if (out_valid_reg && out_ready) begin
                        if (cnt_reg == CNT_LAST) begin
                            out_word_reg <= {2'b01, ctl_reg, 1'b1};
                            state_reg    <= S_SEND_CTL;
                        end else begin
                            c_reg        <= c_shift[W-1:0];
                            out_word_reg <= {2'b00, c_shift[W-1 -: 8], 1'b1};
                            cnt_reg      <= cnt_reg + 5'd1;
                        end
                    end
                end
                S_SEND_CTL, S_ERR_SEND: begin
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_word_reg  <= {2'b01, ctl_reg, 1'b1};
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_word_reg  <= 11'h7FF;
                        a_reg         <= '1;
                        b_reg         <= '1;
                        crc_reg       <= 4'h0;
                        cnt_reg       <= 5'd0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= S_RECV;
                    end
                end
                default: begin
                    state_reg <= S_RECV;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_core_param.sv
// Scoreboard bench for alu_core_param: one 4-byte instance and a 2-byte pair
// (EXT_OPS on/off) fed identical frames.
module tb_alu_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv0, iv1;
    logic [9:0]  if0, if1;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        or0, or1, or2;
    logic [10:0] ow0, ow1, ow2;

    int checks = 0;
    int errors = 0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    alu_core_param #(.DATA_BYTES(4), .EXT_OPS(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_frame(if0), .in_ready(ir0),
        .out_valid(ov0), .out_word(ow0), .out_ready(or0));

    alu_core_param #(.DATA_BYTES(2), .EXT_OPS(1)) u_dut2x (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_frame(if1), .in_ready(ir1),
        .out_valid(ov1), .out_word(ow1), .out_ready(or1));

    alu_core_param #(.DATA_BYTES(2), .EXT_OPS(0)) u_dut2n (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_frame(if1), .in_ready(ir2),
        .out_valid(ov2), .out_word(ow2), .out_ready(or2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ov(input int s);
        return (s == 0) ? ov0 : ((s == 1) ? ov1 : ov2);
    endfunction
    function automatic logic get_ir(input int s);
        return (s == 0) ? ir0 : ((s == 1) ? ir1 : ir2);
    endfunction
    function automatic logic [10:0] get_ow(input int s);
        return (s == 0) ? ow0 : ((s == 1) ? ow1 : ow2);
    endfunction
    function automatic int nb(input int s);
        return (s == 0) ? 4 : 2;
    endfunction

    task automatic set_ordy(input int s, input logic v);
        if (s == 0) or0 = v; else if (s == 1) or1 = v; else or2 = v;
    endtask
    task automatic set_in(input int s, input logic v, input logic [9:0] f);
        if (s == 0) begin iv0 = v; if0 = f; end
        else begin iv1 = v; if1 = f; end
    endtask
    task automatic push(input int s, input logic [10:0] w);
        if (s == 0) q0.push_back(w); else if (s == 1) q1.push_back(w); else q2.push_back(w);
    endtask
    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : ((s == 1) ? q1.size() : q2.size());
    endfunction
    function automatic logic [10:0] pop(input int s);
        if (s == 0) return q0.pop_front();
        if (s == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    function automatic logic [3:0] crc4_ref(input logic [127:0] msg, input int nbits);
        logic [3:0] c = 4'h0;
        logic fb;
        for (int i = nbits - 1; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c = {c[2:0], 1'b0};
            if (fb) c = c ^ 4'b0011;
        end
        return c;
    endfunction

    function automatic logic [2:0] crc3_ref(input logic [127:0] msg, input int nbits);
        logic [2:0] c = 3'h0;
        logic fb;
        for (int i = nbits - 1; i >= 0; i--) begin
            fb = c[2] ^ msg[i];
            c = {c[1:0], 1'b0};
            if (fb) c = c ^ 3'b011;
        end
        return c;
    endfunction

    task automatic alu_model(input int w, input logic [2:0] op, input logic [63:0] a,
                             input logic [63:0] b, output logic [63:0] c, output logic [7:0] ctl);
        logic [64:0]  r;
        logic [63:0]  mask;
        logic         cy, ov, z, n;
        int           sh;
        logic [127:0] msg;
        mask = (64'd1 << w) - 64'd1;
        cy = 1'b0;
        ov = 1'b0;
        case (op)
            3'd0: r = {1'b0, a & b};
            3'd1: r = {1'b0, a | b};
            3'd2: r = {1'b0, a ^ b};
            3'd3: begin
                sh = int'(b % 64'(w));
                r  = {1'b0, a} << sh;
                cy = (sh != 0) ? a[w - sh] : 1'b0;
            end
            3'd4: begin
                r  = {1'b0, a} + {1'b0, b};
                cy = r[w];
            end
            3'd5: begin
                r  = {1'b0, a} - {1'b0, b};
                cy = (a < b);
            end
            default: r = '0;
        endcase
        c = r[63:0] & mask;
        if (op == 3'd4) ov = (a[w-1] == b[w-1]) && (c[w-1] != a[w-1]);
        if (op == 3'd5) ov = (a[w-1] != b[w-1]) && (c[w-1] != a[w-1]);
        z = (c == 64'd0);
        n = c[w-1];
        msg = (128'(c) << 5) | 128'({1'b0, cy, ov, z, n});
        ctl = {1'b0, cy, ov, z, n, crc3_ref(msg, w + 5)};
    endtask

    task automatic expect_pkt(input int s, input logic [63:0] a, input logic [63:0] b,
                              input logic [2:0] op, input logic flip);
        logic        illegal;
        logic [63:0] c;
        logic [7:0]  ctl;
        illegal = (op == 3'd6) || (op == 3'd7) || ((s == 2) && (op == 3'd2 || op == 3'd3));
        if (illegal) begin
            push(s, {2'b01, 8'b10010011, 1'b1});
        end else if (flip) begin
            push(s, {2'b01, 8'b10100101, 1'b1});
        end else begin
            alu_model(8 * nb(s), op, a, b, c, ctl);
            for (int i = nb(s) - 1; i >= 0; i--) push(s, {2'b00, c[8*i +: 8], 1'b1});
            push(s, {2'b01, ctl, 1'b1});
        end
    endtask

    task automatic send_frame(input int s, input logic [9:0] f);
        int n = 0;
        logic rdy;
        @(negedge clk);
        set_in(s, 1'b1, f);
        rdy = (s == 0) ? ir0 : (ir1 && ir2);
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
            rdy = (s == 0) ? ir0 : (ir1 && ir2);
        end
        chk("in_ready_wait", 64'(rdy), 64'd1);
        @(posedge clk);
    endtask

    task automatic send_pkt(input int s, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] op, input logic flip);
        int           w;
        logic [127:0] msg;
        logic [3:0]   crc;
        w   = 8 * nb(s);
        msg = (128'(b) << (w + 4)) | (128'(a) << 4) | 128'({1'b1, op});
        crc = crc4_ref(msg, 2 * w + 4) ^ {3'b000, flip};
        for (int i = nb(s) - 1; i >= 0; i--) send_frame(s, {2'b00, b[8*i +: 8]});
        for (int i = nb(s) - 1; i >= 0; i--) send_frame(s, {2'b00, a[8*i +: 8]});
        send_frame(s, {2'b01, 1'b0, op, crc});
    endtask

    // Called right after the accepting edge k; index i of the loop observes edge k+i.
    task automatic check_lat(input int s, input int exp);
        int l0 = -1, l1 = -1, l2 = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                set_in(s, 1'b0, 10'h000);
                if (s == 0) chk("in_ready_busy", 64'(ir0), 64'd0);
                else chk("in_ready_busy_pair", 64'({ir1, ir2}), 64'd0);
            end
            if (l0 < 0 && ov0) l0 = i;
            if (l1 < 0 && ov1) l1 = i;
            if (l2 < 0 && ov2) l2 = i;
        end
        if (s == 0) begin
            chk("latency", 64'(l0), 64'(exp));
        end else begin
            chk("latency_ext", 64'(l1), 64'(exp));
            chk("latency_noext", 64'(l2), 64'(exp));
        end
    endtask

    task automatic drain(input int s, input logic toggle);
        int          guard = 0;
        logic        stalled = 1'b0;
        logic [10:0] held = '0;
        logic        r;
        while (qsize(s) > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (stalled) begin
                chk("hold_word", 64'(get_ow(s)), 64'(held));
                chk("hold_valid", 64'(get_ov(s)), 64'd1);
            end
            r = toggle ? (guard % 2 == 0) : 1'b1;
            set_ordy(s, r);
            stalled = 1'b0;
            if (get_ov(s)) begin
                if (r) begin
                    chk("out_word", 64'(get_ow(s)), 64'(pop(s)));
                end else begin
                    held = get_ow(s);
                    stalled = 1'b1;
                end
            end
        end
        chk("drain_done", 64'(qsize(s)), 64'd0);
        @(negedge clk);
        set_ordy(s, 1'b0);
        chk("in_ready_back", 64'(get_ir(s)), 64'd1);
        chk("idle_valid", 64'(get_ov(s)), 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb;
        rst_n = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; if0 = '0; if1 = '0;
        or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(ir0), 64'd0);
        chk("reset_out_valid", 64'(ov0), 64'd0);
        chk("reset_out_word", 64'(ow0), 64'h7FF);
        chk("reset_out_word2", 64'(ow1), 64'h7FF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(ir0), 64'd1);
        chk("in_ready_after_reset2", 64'(ir1), 64'd1);

        // ADD with wrap to zero, carry set
        expect_pkt(0, 64'hFFFF_FFFF, 64'h0000_0001, 3'd4, 1'b0);
        send_pkt(0, 64'hFFFF_FFFF, 64'h0000_0001, 3'd4, 1'b0);
        check_lat(0, 2);
        drain(0, 1'b0);

        // SUB with signed overflow, consumer stalling every other cycle
        expect_pkt(0, 64'h8000_0000, 64'h0000_0001, 3'd5, 1'b0);
        send_pkt(0, 64'h8000_0000, 64'h0000_0001, 3'd5, 1'b0);
        check_lat(0, 2);
        drain(0, 1'b1);

        // Illegal opcode, then a CRC with bit 0 flipped
        expect_pkt(0, 64'h1234_5678, 64'h9ABC_DEF0, 3'd7, 1'b0);
        send_pkt(0, 64'h1234_5678, 64'h9ABC_DEF0, 3'd7, 1'b0);
        check_lat(0, 2);
        drain(0, 1'b0);
        expect_pkt(0, 64'h1234_5678, 64'h9ABC_DEF0, 3'd4, 1'b1);
        send_pkt(0, 64'h1234_5678, 64'h9ABC_DEF0, 3'd4, 1'b1);
        check_lat(0, 2);
        drain(0, 1'b0);

        // Command frame arriving at cnt=3, then a clean AND packet
        push(0, {2'b01, 8'b11001001, 1'b1});
        for (int i = 0; i < 3; i++) send_frame(0, {2'b00, 8'h5A});
        send_frame(0, {2'b01, 8'h00});
        check_lat(0, 1);
        drain(0, 1'b0);
        expect_pkt(0, 64'hF0F0_1234, 64'h0FF0_FF00, 3'd0, 1'b0);
        send_pkt(0, 64'hF0F0_1234, 64'h0FF0_FF00, 3'd0, 1'b0);
        check_lat(0, 2);
        drain(0, 1'b0);

        // Start bit set on the very first frame, then a clean XOR packet
        push(0, {2'b01, 8'b11001001, 1'b1});
        send_frame(0, 10'b10_0000_0000);
        check_lat(0, 1);
        drain(0, 1'b0);
        expect_pkt(0, 64'hA5A5_0F0F, 64'h5A5A_FFFF, 3'd2, 1'b0);
        send_pkt(0, 64'hA5A5_0F0F, 64'h5A5A_FFFF, 3'd2, 1'b0);
        check_lat(0, 2);
        drain(0, 1'b0);

        // Every legal opcode with random operands
        for (int op = 0; op < 6; op++) begin
            ra = 64'($urandom);
            rb = 64'($urandom);
            expect_pkt(0, ra, rb, 3'(op), 1'b0);
            send_pkt(0, ra, rb, 3'(op), 1'b0);
            check_lat(0, 2);
            drain(0, 1'(op % 2));
        end

        // 2-byte SHL: legal with EXT_OPS=1, opcode error with EXT_OPS=0
        expect_pkt(1, 64'h8001, 64'h0001, 3'd3, 1'b0);
        expect_pkt(2, 64'h8001, 64'h0001, 3'd3, 1'b0);
        send_pkt(1, 64'h8001, 64'h0001, 3'd3, 1'b0);
        check_lat(1, 2);
        drain(1, 1'b0);
        drain(2, 1'b0);
        expect_pkt(1, 64'h7FFF, 64'h0001, 3'd4, 1'b0);
        expect_pkt(2, 64'h7FFF, 64'h0001, 3'd4, 1'b0);
        send_pkt(1, 64'h7FFF, 64'h0001, 3'd4, 1'b0);
        check_lat(1, 2);
        drain(1, 1'b1);
        drain(2, 1'b0);

        // Reset after 5 frames discards the partial packet
        for (int i = 0; i < 5; i++) send_frame(0, {2'b00, 8'(8'h11 * (i + 1))});
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0, 1'b0, 10'h000);
        @(negedge clk);
        chk("abort_out_word", 64'(ow0), 64'h7FF);
        chk("abort_out_valid", 64'(ov0), 64'd0);
        chk("abort_in_ready", 64'(ir0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready_back", 64'(ir0), 64'd1);
        expect_pkt(0, 64'hDEAD_BEEF, 64'hFFFF_0000, 3'd0, 1'b0);
        send_pkt(0, 64'hDEAD_BEEF, 64'hFFFF_0000, 3'd0, 1'b0);
        check_lat(0, 2);
        drain(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
